// File: rtl/factorial_pkg.sv
// factorial_pkg
//   Shared constants for the factorial system: bus address map, core
//   register offsets, the core state encoding and an address-range helper.
package factorial_pkg;

  localparam int DATA_W    = 64;
  localparam int RES_W     = 128;
  localparam int ADDR_W    = 16;
  localparam int OFF_W     = 8;
  localparam int RAM_DEPTH = 256;
  localparam int RAM_IDX_W = 8;

  // Address map (byte addresses)
  localparam logic [ADDR_W-1:0] RAM_BASE  = 16'h0000;
  localparam logic [ADDR_W-1:0] RAM_LAST  = 16'h07FF;
  localparam logic [ADDR_W-1:0] CORE_BASE = 16'h7000;
  localparam logic [ADDR_W-1:0] CORE_LAST = 16'h70FF;

  // Core register offsets
  localparam logic [OFF_W-1:0] OPSTART  = 8'h00;
  localparam logic [OFF_W-1:0] OPCLEAR  = 8'h08;
  localparam logic [OFF_W-1:0] OPDONE   = 8'h10;
  localparam logic [OFF_W-1:0] INTREN   = 8'h18;
  localparam logic [OFF_W-1:0] OPERAND  = 8'h20;
  localparam logic [OFF_W-1:0] RESULT_H = 8'h28;
  localparam logic [OFF_W-1:0] RESULT_L = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } core_state_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] lo,
                                    input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/factorial_core.sv
// factorial_core
//   Memory-mapped factorial accelerator. Computes operand! truncated to
//   128 bits by repeated multiply-and-decrement, one step per clock.
// Ports:
//   clk        system clock (rising edge)
//   reset_n    asynchronous active-low reset
//   select     bus transfer addressed to this core this cycle
//   wr         1 = write, 0 = read
//   offset     register byte offset (bits [2:0] ignored)
//   wdata      write data
//   rdata      combinational read data for the addressed register
//   interrupt  done & intrEn
module factorial_core
  import factorial_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              select,
  input  logic              wr,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              interrupt
);

  core_state_e        state_q, state_d;
  logic [RES_W-1:0]   result_q;
  logic [DATA_W-1:0]  cnt_q;
  logic [DATA_W-1:0]  operand_q;
  logic               intr_en_q;
  logic               done_q;

  logic [OFF_W-1:0]   reg_off;
  logic               wr_en;
  logic               start_req;
  logic               clear_req;
  logic               start_ok;
  logic               busy;
  logic [RES_W-1:0]   product;
  logic               unused_off;

  // Registers are 64-bit words; the byte lane bits do not select anything.
  assign reg_off    = {offset[OFF_W-1:3], 3'b000};
  assign unused_off = ^offset[2:0];

  assign wr_en     = select & wr;
  assign start_req = wr_en && (reg_off == OPSTART) && wdata[0];
  assign clear_req = wr_en && (reg_off == OPCLEAR) && wdata[0];
  // Clear wins over a start presented on the same edge.
  assign start_ok  = start_req && !clear_req && (state_q != BUSY);

  // Product is formed at full 128 bits; the upper bits of the true
  // 192-bit product are discarded so large operands wrap.
  assign product = result_q * RES_W'(cnt_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) state_d = BUSY;
        BUSY:    if (cnt_q <= 64'd1) state_d = DONE;
        DONE:    if (start_ok) state_d = BUSY;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and programmer-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q  <= '0;
      cnt_q     <= '0;
      operand_q <= '0;
      intr_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (clear_req) begin
        result_q <= '0;
        cnt_q    <= '0;
        done_q   <= 1'b0;
      end else if (start_ok) begin
        result_q <= RES_W'(1);
        cnt_q    <= operand_q;
        done_q   <= 1'b0;
      end else if (state_q == BUSY) begin
        if (cnt_q <= 64'd1) begin
          done_q <= 1'b1;
        end else begin
          result_q <= product;
          cnt_q    <= cnt_q - 64'd1;
        end
      end

      if (wr_en && (reg_off == OPERAND) && (state_q != BUSY))
        operand_q <= wdata;

      if (wr_en && (reg_off == INTREN))
        intr_en_q <= wdata[0];
    end
  end

  // Outputs: read mux and interrupt
  always_comb begin
    busy      = (state_q == BUSY);
    interrupt = done_q & intr_en_q;
    rdata     = '0;
    case (reg_off)
      OPDONE:   rdata = {62'b0, busy, done_q};
      INTREN:   rdata = {63'b0, intr_en_q};
      OPERAND:  rdata = operand_q;
      RESULT_H: rdata = result_q[RES_W-1:DATA_W];
      RESULT_L: rdata = result_q[DATA_W-1:0];
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/factorial_top.sv
// factorial_top
//   Single-master 64-bit bus fabric joining a 256x64 data RAM and the
//   factorial core. Decodes the address, muxes read data and registers it.
// Ports:
//   clk        system clock (rising edge)
//   reset_n    asynchronous active-low reset
//   m_req      master requests the bus
//   m_wr       1 = write, 0 = read
//   m_addr     byte address (bits [2:0] ignored)
//   m_dout     write data from the master
//   m_grant    bus grant (m_req & reset_n)
//   m_din      registered read data, 0 on edges without a read
//   interrupt  factorial-done interrupt
module factorial_top
  import factorial_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m_req,
  input  logic              m_wr,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_dout,
  output logic              m_grant,
  output logic [DATA_W-1:0] m_din,
  output logic              interrupt
);

  logic [DATA_W-1:0]    ram_q [RAM_DEPTH];
  logic [DATA_W-1:0]    m_din_q;
  logic [DATA_W-1:0]    rd_data_d;
  logic [DATA_W-1:0]    core_rdata;
  logic [RAM_IDX_W-1:0] ram_idx;
  logic                 transfer;
  logic                 ram_hit;
  logic                 core_hit;
  logic                 core_irq;

  // Only one master, so grant is just the request qualified by reset.
  assign m_grant  = m_req & reset_n;
  assign transfer = m_req & m_grant;

  assign ram_hit  = in_range(m_addr, RAM_BASE, RAM_LAST);
  assign core_hit = in_range(m_addr, CORE_BASE, CORE_LAST);
  assign ram_idx  = m_addr[10:3];

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (transfer && m_wr && ram_hit)
      ram_q[ram_idx] <= m_dout;
  end

  factorial_core u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .select    (transfer & core_hit),
    .wr        (m_wr),
    .offset    (m_addr[7:0]),
    .wdata     (m_dout),
    .rdata     (core_rdata),
    .interrupt (core_irq)
  );

  always_comb begin
    rd_data_d = '0;
    if (ram_hit)       rd_data_d = ram_q[ram_idx];
    else if (core_hit) rd_data_d = core_rdata;
  end

  // Read data is captured from pre-edge state; idle edges clear it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                m_din_q <= '0;
    else if (transfer && !m_wr) m_din_q <= rd_data_d;
    else                         m_din_q <= '0;
  end

  assign m_din     = m_din_q;
  assign interrupt = core_irq;

endmodule

// File: tb/tb_factorial_top.sv
module tb_factorial_top;

  logic        clk;
  logic        reset_n;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;
  logic        interrupt;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [15:0] A_START = 16'h7000;
  localparam logic [15:0] A_CLEAR = 16'h7008;
  localparam logic [15:0] A_DONE  = 16'h7010;
  localparam logic [15:0] A_IEN   = 16'h7018;
  localparam logic [15:0] A_OPND  = 16'h7020;
  localparam logic [15:0] A_RESH  = 16'h7028;
  localparam logic [15:0] A_RESL  = 16'h7030;

  factorial_top dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .m_grant   (m_grant),
    .m_din     (m_din),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    m_req  = 1'b1;
    m_wr   = 1'b1;
    m_addr = a;
    m_dout = d;
    tick();
    m_req  = 1'b0;
    m_wr   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [63:0] exp, input string tag);
    m_req  = 1'b1;
    m_wr   = 1'b0;
    m_addr = a;
    #1;
    chk({tag, "_grant"}, 128'(m_grant), 128'(1));
    @(posedge clk);
    #1;
    m_req = 1'b0;
    chk(tag, 128'(m_din), 128'(exp));
  endtask

  logic [127:0] f25;
  logic [127:0] f34;

  initial begin
    f25 = 128'd15511210043330985984000000;
    f34 = 128'd1;
    for (int i = 2; i <= 34; i++) f34 = f34 * 128'(i);

    // Reset
    reset_n = 1'b0;
    m_req   = 1'b1;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_dout  = '0;
    #10;
    chk("rst_grant", 128'(m_grant), 128'(0));
    chk("rst_din", 128'(m_din), 128'(0));
    chk("rst_irq", 128'(interrupt), 128'(0));
    m_req = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("grant_idle", 128'(m_grant), 128'(0));

    // RAM write / readback
    for (int i = 0; i < 6; i++) wr(16'h0020 + 16'(8 * i), 64'(5 * i));
    rd(16'h0048, 64'd25, "ram_48");
    rd(16'h0040, 64'd20, "ram_40");
    rd(16'h0038, 64'd15, "ram_38");
    rd(16'h0030, 64'd10, "ram_30");
    rd(16'h0028, 64'd5,  "ram_28");
    tick();
    chk("din_idle_zero", 128'(m_din), 128'(0));
    chk("grant_drop", 128'(m_grant), 128'(0));

    // Unmapped access must not alias into RAM word 0
    wr(16'h0000, 64'h1234);
    wr(16'h4000, 64'hDEAD);
    rd(16'h4000, 64'd0, "unmapped_rd");
    rd(16'h0000, 64'h1234, "ram0_intact");

    // Factorial 5
    wr(A_OPND, 64'd5);
    wr(A_IEN, 64'd1);
    wr(A_START, 64'd1);
    rd(A_DONE, 64'd2, "f5_busy");
    repeat (3) tick();
    chk("f5_irq_early", 128'(interrupt), 128'(0));
    tick();
    chk("f5_irq", 128'(interrupt), 128'(1));
    rd(A_DONE, 64'd1, "f5_done");
    rd(A_RESL, 64'd120, "f5_resl");
    rd(A_RESH, 64'd0, "f5_resh");
    wr(A_IEN, 64'd0);
    chk("ien_off_irq", 128'(interrupt), 128'(0));
    wr(A_IEN, 64'd1);
    chk("ien_on_irq", 128'(interrupt), 128'(1));

    // Operand 0, restarted from DONE
    wr(A_OPND, 64'd0);
    wr(A_START, 64'd1);
    chk("f0_start_irq", 128'(interrupt), 128'(0));
    tick();
    chk("f0_irq", 128'(interrupt), 128'(1));
    rd(A_RESL, 64'd1, "f0_resl");
    rd(A_RESH, 64'd0, "f0_resh");

    // Operand 25
    wr(A_OPND, 64'd25);
    wr(A_START, 64'd1);
    repeat (24) tick();
    chk("f25_irq_early", 128'(interrupt), 128'(0));
    tick();
    chk("f25_irq", 128'(interrupt), 128'(1));
    rd(A_RESH, f25[127:64], "f25_resh");
    rd(A_RESL, f25[63:0], "f25_resl");

    // Operand 34
    wr(A_OPND, 64'd34);
    wr(A_START, 64'd1);
    repeat (33) tick();
    chk("f34_irq_early", 128'(interrupt), 128'(0));
    tick();
    chk("f34_irq", 128'(interrupt), 128'(1));
    rd(A_RESH, f34[127:64], "f34_resh");
    rd(A_RESL, f34[63:0], "f34_resl");

    // Start and operand write while BUSY are ignored
    wr(A_OPND, 64'd10);
    wr(A_START, 64'd1);
    tick();
    tick();
    wr(A_OPND, 64'd3);
    wr(A_START, 64'd1);
    repeat (5) tick();
    chk("busy_irq_early", 128'(interrupt), 128'(0));
    tick();
    chk("busy_irq", 128'(interrupt), 128'(1));
    rd(A_RESL, 64'd3628800, "f10_resl");
    rd(A_OPND, 64'd10, "busy_opnd_kept");

    // Clear mid-computation
    wr(A_OPND, 64'd6);
    wr(A_START, 64'd1);
    tick();
    tick();
    wr(A_CLEAR, 64'd1);
    chk("clr_irq", 128'(interrupt), 128'(0));
    rd(A_DONE, 64'd0, "clr_idle");
    repeat (8) tick();
    rd(A_DONE, 64'd0, "clr_stays_idle");
    rd(A_RESL, 64'd0, "clr_resl");
    rd(A_OPND, 64'd6, "clr_opnd_kept");
    rd(A_IEN, 64'd1, "clr_ien_kept");

    // Reset pulse mid-computation
    wr(A_OPND, 64'd7);
    wr(A_START, 64'd1);
    rd(A_DONE, 64'd2, "rst_mid_busy");
    m_req   = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("rst_mid_din", 128'(m_din), 128'(0));
    chk("rst_mid_grant", 128'(m_grant), 128'(0));
    chk("rst_mid_irq", 128'(interrupt), 128'(0));
    m_req   = 1'b0;
    reset_n = 1'b1;
    tick();
    rd(A_DONE, 64'd0, "rst_mid_done");
    rd(A_OPND, 64'd0, "rst_mid_opnd");
    rd(A_IEN, 64'd0, "rst_mid_ien");
    rd(A_RESL, 64'd0, "rst_mid_resl");
    repeat (10) tick();
    chk("rst_mid_irq_later", 128'(interrupt), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
